// File: rtl/arf_tagged_regfile.sv
// Architectural register file with per-entry rename tag and busy bit, tag-qualified writeback and flush.
// Define ARF_BYPASS_EN to forward matching same-cycle writebacks onto the read ports.
module arf_entry #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 4,
  parameter int ADDR_W = 5,
  parameter int NWB    = 2,
  parameter int NREN   = 2,
  parameter int IDX    = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic [NWB-1:0]                 wb_valid,
  input  logic [NWB*ADDR_W-1:0]          wb_addr,
  input  logic [NWB*TAG_W-1:0]           wb_tag,
  input  logic [NWB*DATA_W-1:0]          wb_data,
  input  logic [NREN-1:0]                ren_valid,
  input  logic [NREN*ADDR_W-1:0]         ren_addr,
  input  logic [NREN*TAG_W-1:0]          ren_tag,
  output logic [DATA_W+TAG_W:0]          q
);
  localparam logic [ADDR_W-1:0] ME = ADDR_W'(IDX);

  logic [TAG_W-1:0]  tag,  tag_n;
  logic              busy, busy_n;
  logic [DATA_W-1:0] data, data_n;

  // Writebacks match on pre-edge tag/busy; later ports overwrite earlier ones.
  // Rename (unless flushed) then sets the final busy/tag.
  always_comb begin
    data_n = data;
    busy_n = busy;
    tag_n  = tag;
    for (int k = 0; k < NWB; k++)
      if (wb_valid[k] && wb_addr[k*ADDR_W +: ADDR_W] == ME && busy &&
          tag == wb_tag[k*TAG_W +: TAG_W]) begin
        data_n = wb_data[k*DATA_W +: DATA_W];
        busy_n = 1'b0;
      end
    if (flush) begin
      busy_n = 1'b0;
      tag_n  = '0;
    end else begin
      for (int k = 0; k < NREN; k++)
        if (ren_valid[k] && ren_addr[k*ADDR_W +: ADDR_W] == ME) begin
          busy_n = 1'b1;
          tag_n  = ren_tag[k*TAG_W +: TAG_W];
        end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag  <= '0;
      busy <= 1'b0;
      data <= '0;
    end else begin
      tag  <= tag_n;
      busy <= busy_n;
      data <= data_n;
    end
  end

  assign q = {tag, busy, data};
endmodule

module arf_tagged_regfile #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 4,
  parameter int NREG   = 32,
  parameter int NRD    = 4,
  parameter int NWB    = 2,
  parameter int NREN   = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              rd_en,
  input  logic [NRD*$clog2(NREG)-1:0]       rd_addr,
  output logic [NRD*(DATA_W+TAG_W+1)-1:0]   rd_data,
  output logic                              rd_vld,
  input  logic [NREN-1:0]                   ren_valid,
  input  logic [NREN*$clog2(NREG)-1:0]      ren_addr,
  input  logic [NREN*TAG_W-1:0]             ren_tag,
  input  logic [NWB-1:0]                    wb_valid,
  input  logic [NWB*$clog2(NREG)-1:0]       wb_addr,
  input  logic [NWB*TAG_W-1:0]              wb_tag,
  input  logic [NWB*DATA_W-1:0]             wb_data,
  input  logic                              flush,
  output logic [NREG-1:0]                   busy_vec
);
  localparam int ADDR_W = $clog2(NREG);
  localparam int E      = DATA_W + TAG_W + 1;

  logic [NREG-1:0][E-1:0] ent;
  logic [NRD-1:0][E-1:0]  rd_nxt, rd_q;

  for (genvar i = 0; i < NREG; i++) begin : g_ent
    arf_entry #(
      .DATA_W(DATA_W), .TAG_W(TAG_W), .ADDR_W(ADDR_W),
      .NWB(NWB), .NREN(NREN), .IDX(i)
    ) u_ent (
      .clk(clk), .rst(rst), .flush(flush),
      .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_tag(wb_tag), .wb_data(wb_data),
      .ren_valid(ren_valid), .ren_addr(ren_addr), .ren_tag(ren_tag),
      .q(ent[i])
    );
    assign busy_vec[i] = ent[i][DATA_W];
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [ADDR_W-1:0] a;
    assign a = rd_addr[p*ADDR_W +: ADDR_W];
`ifdef ARF_BYPASS_EN
    // Forward a matching writeback; the tag shown is the pre-edge one (renames never bypass).
    always_comb begin
      rd_nxt[p] = ent[a];
      for (int k = 0; k < NWB; k++)
        if (wb_valid[k] && wb_addr[k*ADDR_W +: ADDR_W] == a && ent[a][DATA_W] &&
            ent[a][E-1 -: TAG_W] == wb_tag[k*TAG_W +: TAG_W])
          rd_nxt[p] = {ent[a][E-1 -: TAG_W], 1'b0, wb_data[k*DATA_W +: DATA_W]};
    end
`else
    assign rd_nxt[p] = ent[a];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q   <= '0;
      rd_vld <= 1'b0;
    end else begin
      rd_vld <= rd_en;
      if (rd_en) rd_q <= rd_nxt;
    end
  end

  assign rd_data = rd_q;
endmodule

// File: tb/tb_arf_tagged_regfile.sv
// Table-driven bench for arf_tagged_regfile (default parameters); expectations follow ARF_BYPASS_EN.
module tb_arf_tagged_regfile;
  logic        clk = 1'b0;
  logic        rst, rd_en, flush;
  logic [19:0] rd_addr;
  logic [83:0] rd_data;
  logic        rd_vld;
  logic [1:0]  ren_valid, wb_valid;
  logic [9:0]  ren_addr, wb_addr;
  logic [7:0]  ren_tag, wb_tag;
  logic [31:0] wb_data;
  logic [31:0] busy_vec;

  arf_tagged_regfile dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_vld(rd_vld), .ren_valid(ren_valid), .ren_addr(ren_addr), .ren_tag(ren_tag),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_tag(wb_tag), .wb_data(wb_data),
    .flush(flush), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst, rd_en, flush;
    logic [19:0] rd_addr;
    logic [1:0]  ren_valid;
    logic [9:0]  ren_addr;
    logic [7:0]  ren_tag;
    logic [1:0]  wb_valid;
    logic [9:0]  wb_addr;
    logic [7:0]  wb_tag;
    logic [31:0] wb_data;
    logic        chk_rd;
    logic [83:0] exp_rd;
    logic        exp_vld;
    logic [31:0] exp_busy;
  } vec_t;

  vec_t v;
  vec_t vq[$];
  int   nchk = 0, nerr = 0;

  function automatic logic [20:0] en(input int t, input int b, input int d);
    return {4'(t), 1'(b), 16'(d)};
  endfunction

  task automatic nv();
    v = '0;
  endtask
  task automatic rd(input int p, input int a, input logic [20:0] e);
    v.rd_en = 1'b1; v.exp_vld = 1'b1; v.chk_rd = 1'b1;
    v.rd_addr[p*5 +: 5] = 5'(a);
    v.exp_rd[p*21 +: 21] = e;
  endtask
  task automatic hold(input int p, input logic [20:0] e);
    v.chk_rd = 1'b1;
    v.exp_rd[p*21 +: 21] = e;
  endtask
  task automatic ren(input int p, input int a, input int t);
    v.ren_valid[p] = 1'b1;
    v.ren_addr[p*5 +: 5] = 5'(a);
    v.ren_tag[p*4 +: 4] = 4'(t);
  endtask
  task automatic wb(input int p, input int a, input int t, input int d);
    v.wb_valid[p] = 1'b1;
    v.wb_addr[p*5 +: 5] = 5'(a);
    v.wb_tag[p*4 +: 4] = 4'(t);
    v.wb_data[p*16 +: 16] = 16'(d);
  endtask
  task automatic push(input logic [31:0] b);
    v.exp_busy = b;
    vq.push_back(v);
  endtask

  task automatic drive(input vec_t x);
    rst = x.rst; rd_en = x.rd_en; flush = x.flush; rd_addr = x.rd_addr;
    ren_valid = x.ren_valid; ren_addr = x.ren_addr; ren_tag = x.ren_tag;
    wb_valid = x.wb_valid; wb_addr = x.wb_addr; wb_tag = x.wb_tag; wb_data = x.wb_data;
  endtask

  task automatic chk(input string nm, input int idx, input logic [83:0] act, input logic [83:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s vec %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  initial begin
    // reset, then multi-port read of reset state
    nv(); v.rst = 1'b1; v.rd_en = 1'b1; v.rd_addr = {5'd31, 5'd17, 5'd5, 5'd0}; v.chk_rd = 1'b1; push(32'h0);
    nv(); rd(0, 0, 0); rd(1, 5, 0); rd(2, 17, 0); rd(3, 31, 0); push(32'h0);
    nv(); push(32'h0);
    // rename then matching writeback
    nv(); ren(0, 7, 3); push(32'h80);
    nv(); wb(0, 7, 3, 'h1234); push(32'h0);
    nv(); rd(0, 7, en(3, 0, 'h1234)); push(32'h0);
    // stale writeback (also: rd_data holds while rd_en low)
    nv(); ren(0, 5, 2); hold(0, en(3, 0, 'h1234)); push(32'h20);
    nv(); ren(1, 5, 9); push(32'h20);
    nv(); wb(0, 5, 2, 'hAAAA); rd(0, 5, en(9, 1, 0)); push(32'h20);
    nv(); rd(0, 5, en(9, 1, 0)); push(32'h20);
    nv(); wb(1, 5, 9, 'hBBBB); push(32'h0);
    nv(); rd(0, 5, en(9, 0, 'hBBBB)); push(32'h0);
    // two writebacks to r2: port 1 wins
    nv(); ren(1, 2, 1); push(32'h4);
    nv(); wb(0, 2, 1, 'h0001); wb(1, 2, 1, 'h0002); push(32'h0);
    nv(); rd(0, 2, en(1, 0, 'h0002)); push(32'h0);
    // rename + matching writeback on r2 in one cycle
    nv(); ren(0, 2, 5); push(32'h4);
    nv(); ren(0, 2, 4); wb(1, 2, 5, 'h0055); push(32'h4);
    nv(); rd(0, 2, en(4, 1, 'h0055)); push(32'h4);
    // two renames to r4: port 1 wins, so tag 7 writeback is stale
    nv(); ren(0, 4, 7); ren(1, 4, 8); push(32'h14);
    nv(); wb(0, 4, 7, 'h7777); rd(0, 4, en(8, 1, 0)); push(32'h14);
    // flush with rename of r10 and matched writeback to r3
    nv(); ren(0, 1, 1); ren(1, 3, 2); push(32'h1E);
    nv(); ren(0, 8, 3); push(32'h11E);
    nv(); v.flush = 1'b1; ren(0, 10, 5); wb(0, 3, 2, 'h3333);
`ifdef ARF_BYPASS_EN
    rd(0, 3, en(2, 0, 'h3333));
`else
    rd(0, 3, en(2, 1, 0));
`endif
    push(32'h0);
    nv(); rd(0, 3, en(0, 0, 'h3333)); rd(1, 10, 0); rd(2, 1, 0); rd(3, 8, 0); push(32'h0);
    // read racing a matching writeback on r11
    nv(); ren(1, 11, 6); push(32'h800);
    nv(); wb(1, 11, 6, 'h00FF);
`ifdef ARF_BYPASS_EN
    rd(2, 11, en(6, 0, 'h00FF));
`else
    rd(2, 11, en(6, 1, 0));
`endif
    push(32'h0);
    nv(); rd(0, 11, en(6, 0, 'h00FF)); push(32'h0);

    drive('0);
    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i]);
      @(posedge clk); #1;
      chk("rd_vld", i, 84'(rd_vld), 84'(vq[i].exp_vld));
      chk("busy_vec", i, 84'(busy_vec), 84'(vq[i].exp_busy));
      if (vq[i].chk_rd) chk("rd_data", i, rd_data, vq[i].exp_rd);
    end

    // reset overrides a concurrent rename and read
    nv(); v.rst = 1'b1; ren(0, 9, 4); rd(0, 11, 0); drive(v);
    @(posedge clk); #1;
    chk("rst_vld", 100, 84'(rd_vld), 84'(0));
    chk("rst_data", 100, rd_data, 84'(0));
    chk("rst_busy", 100, 84'(busy_vec), 84'(0));
    nv(); rd(0, 11, 0); rd(1, 7, 0); rd(2, 9, 0); drive(v);
    @(posedge clk); #1;
    chk("post_rst_data", 101, rd_data, 84'(0));
    chk("post_rst_vld", 101, 84'(rd_vld), 84'(1));
    drive('0);
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
